// File: rtl/dma_copy_engine.sv
// Block copy bus initiator: moves len 16-bit words from src.. to dst.., one read then one
// write per word in ascending order, only while the arbiter grants the shared data bus.
//
// state   | meaning
// S_IDLE  | waiting for start; nothing driven
// S_REQ   | bus requested, waiting for the first grant
// S_READ  | read cycle at src+idx; stalls while grant is low
// S_WRITE | write of the held word to dst+idx; stalls while grant is low
// S_DONE  | one-cycle completion pulse, bus released
module dma_copy_engine #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  bus_req,
   input  logic                  bus_grant,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  read,
   output logic                  write,
   inout  wire  [DATA_WIDTH-1:0] bus_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   src_q;
   logic [ADDR_WIDTH-1:0]   dst_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    idx_q;
   logic [DATA_WIDTH-1:0]   hold_q;
   logic [LEN_WIDTH-1:0]    idx_inc;
   logic                    last_word;
   logic [ADDR_WIDTH-1:0]   src_cur;
   logic [ADDR_WIDTH-1:0]   dst_cur;
   logic                    drive_en;

   // idx never exceeds len-1, so idx+1 cannot overflow LEN_WIDTH
   assign idx_inc   = idx_q + 1'b1;
   assign last_word = (idx_inc == len_q);

   // address arithmetic wraps modulo 2^ADDR_WIDTH
   assign src_cur = src_q + ADDR_WIDTH'(idx_q);
   assign dst_cur = dst_q + ADDR_WIDTH'(idx_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (length == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (bus_grant) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (bus_grant) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus_grant) begin
               state_d = last_word ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes are masked by rst so an aborting edge never commits a bus cycle.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      bus_req  = 1'b0;
      read     = 1'b0;
      write    = 1'b0;
      bus_addr = '0;
      drive_en = 1'b0;
      case (state_q)
         S_REQ: begin
            busy     = 1'b1;
            bus_req  = 1'b1;
            bus_addr = src_cur;
         end
         S_READ: begin
            busy     = 1'b1;
            bus_req  = 1'b1;
            read     = bus_grant && !rst;
            bus_addr = src_cur;
         end
         S_WRITE: begin
            busy     = 1'b1;
            bus_req  = 1'b1;
            write    = bus_grant && !rst;
            drive_en = bus_grant && !rst;
            bus_addr = dst_cur;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign bus_data = drive_en ? hold_q : 'z;

   // Transfer parameters are captured only in IDLE, so start while busy or in DONE is inert.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         idx_q  <= '0;
         hold_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (length != '0)) begin
                  src_q <= src_addr;
                  dst_q <= dst_addr;
                  len_q <= length;
                  idx_q <= '0;
               end
            end
            S_READ: begin
               if (bus_grant) begin
                  hold_q <= bus_data;
               end
            end
            S_WRITE: begin
               if (bus_grant) begin
                  idx_q <= idx_inc;
               end
            end
            default: begin
               idx_q <= idx_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: memory responder, bus monitor feeding observed-cycle queues,
// a table of immediate-grant transfers, and hand sequences for stall, abort and restart.
module tb_dma_copy_engine;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int LW = 16;

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [LW-1:0] len;
      int            exp_lat;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [LW-1:0] length;
   logic          busy;
   logic          done;
   logic          bus_req;
   logic          bus_grant;
   logic [AW-1:0] bus_addr;
   logic          read;
   logic          write;
   wire  [DW-1:0] bus_data;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   wr_t           exp_wr[$];
   wr_t           obs_wr[$];
   logic [AW-1:0] exp_rd[$];
   logic [AW-1:0] obs_rd[$];
   logic [DW-1:0] shadow [logic [AW-1:0]];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int act_cnt  = 0;

   dma_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .bus_req  (bus_req),
      .bus_grant(bus_grant),
      .bus_addr (bus_addr),
      .read     (read),
      .write    (write),
      .bus_data (bus_data)
   );

   always #5 clk = ~clk;

   // asynchronous-read, synchronous-write memory responder plus a backdoor port
   assign bus_data = read ? mem[bus_addr] : 'z;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (write) mem[bus_addr] <= bus_data;
   end

   // strobes only change after posedge, so the negedge view is what the next edge commits
   always @(negedge clk) begin
      if (read) obs_rd.push_back(bus_addr);
      if (write) obs_wr.push_back('{bus_addr, bus_data});
      if (done) done_cnt <= done_cnt + 1;
      if (bus_req || read || write) act_cnt <= act_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic undriven(input logic [DW-1:0] v);
      return (v === {DW{1'bz}}) || (v === '0);
   endfunction

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   // fills the source range and builds the expected read/write sequence, overlap included
   task automatic prep(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
      logic [31:0]   r;
      logic [AW-1:0] a;
      logic [AW-1:0] w;
      logic [DW-1:0] v;
      exp_wr.delete(); exp_rd.delete(); obs_wr.delete(); obs_rd.delete(); shadow.delete();
      for (int i = 0; i < int'(n); i++) begin
         r = $urandom;
         poke(s + AW'(i), r[DW-1:0] | 16'h0001);
      end
      for (int i = 0; i < int'(n); i++) begin
         a = s + AW'(i);
         w = d + AW'(i);
         v = shadow.exists(a) ? shadow[a] : mem[a];
         exp_rd.push_back(a);
         exp_wr.push_back('{w, v});
         shadow[w] = v;
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [LW-1:0] n, output int t0);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; length = n; start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - t0;
            return;
         end
      end
   endtask

   task automatic drain();
      wr_t           o;
      wr_t           e;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      check("wr_count", obs_wr.size(), exp_wr.size());
      check("rd_count", obs_rd.size(), exp_rd.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
         o = obs_wr.pop_front();
         e = exp_wr.pop_front();
         check("wr_addr", o.addr, e.addr);
         check("wr_data", o.data, e.data);
      end
      while (obs_rd.size() > 0 && exp_rd.size() > 0) begin
         ra = obs_rd.pop_front();
         rb = exp_rd.pop_front();
         check("rd_addr", ra, rb);
      end
      exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
   endtask

   task automatic check_mem();
      foreach (shadow[a]) check("mem_dst", mem[a], shadow[a]);
   endtask

   vec_t vecs[6];

   initial begin
      int t0;
      int lat;
      int a0;
      int d0;

      vecs[0] = '{src: 20'h00100, dst: 20'h00200, len: 16'd4, exp_lat: 10};
      vecs[1] = '{src: 20'h00000, dst: 20'h00300, len: 16'd0, exp_lat: 1};
      vecs[2] = '{src: 20'hFFFFE, dst: 20'h00400, len: 16'd3, exp_lat: 8};
      vecs[3] = '{src: 20'h00500, dst: 20'hFFFFF, len: 16'd2, exp_lat: 6};
      vecs[4] = '{src: 20'h00600, dst: 20'h00700, len: 16'd1, exp_lat: 4};
      vecs[5] = '{src: 20'h00800, dst: 20'h00801, len: 16'd3, exp_lat: 8};

      rst = 1'b1; start = 1'b0; bus_grant = 1'b1;
      src_addr = '0; dst_addr = '0; length = '0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_read", read, 0);
      check("rst_write", write, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_data_z", undriven(bus_data), 1);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[k]) begin
         prep(vecs[k].src, vecs[k].dst, vecs[k].len);
         a0 = act_cnt;
         d0 = done_cnt;
         pulse_start(vecs[k].src, vecs[k].dst, vecs[k].len, t0);
         check("busy_after_start", busy, (vecs[k].len != 0));
         wait_done(t0, lat);
         check("latency", lat, vecs[k].exp_lat);
         check("busy_at_done", busy, 0);
         check("bus_req_at_done", bus_req, 0);
         check("bus_active_cycles", act_cnt - a0, vecs[k].exp_lat - 1);
         repeat (2) @(negedge clk);
         check("done_pulses", done_cnt - d0, 1);
         drain();
         check_mem();
      end

      // grant withdrawn for 3 cycles during the write of word 1
      prep(20'h00900, 20'h00A00, 16'd4);
      pulse_start(20'h00900, 20'h00A00, 16'd4, t0);
      repeat (4) begin @(posedge clk); #1; end
      bus_grant = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("stall_write", write, 0);
         check("stall_read", read, 0);
         check("stall_bus_data_z", undriven(bus_data), 1);
         check("stall_bus_addr", bus_addr, 20'h00A01);
         check("stall_bus_req", bus_req, 1);
         @(posedge clk); #1;
      end
      bus_grant = 1'b1;
      wait_done(t0, lat);
      check("stall_latency", lat, 13);
      drain();
      check_mem();

      // reset during the write of word 2 of 4
      poke(20'h00C02, 16'h5A5A);
      poke(20'h00C03, 16'h5A5B);
      prep(20'h00B00, 20'h00C00, 16'd4);
      pulse_start(20'h00B00, 20'h00C00, 16'd4, t0);
      repeat (6) begin @(posedge clk); #1; end
      check("abort_in_write2", bus_addr, 20'h00C02);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_bus_req", bus_req, 0);
      check("abort_read", read, 0);
      check("abort_write", write, 0);
      check("abort_bus_addr", bus_addr, 0);
      check("abort_bus_data_z", undriven(bus_data), 1);
      void'(exp_wr.pop_back()); void'(exp_wr.pop_back());
      void'(exp_rd.pop_back());
      drain();
      check("abort_mem0", mem[20'h00C00], shadow[20'h00C00]);
      check("abort_mem1", mem[20'h00C01], shadow[20'h00C01]);
      check("abort_mem2", mem[20'h00C02], 16'h5A5A);
      check("abort_mem3", mem[20'h00C03], 16'h5A5B);

      // start while busy and start in the DONE cycle are both ignored
      poke(20'h00F80, 16'h1234);
      prep(20'h00D00, 20'h00E00, 16'd4);
      d0 = done_cnt;
      pulse_start(20'h00D00, 20'h00E00, 16'd4, t0);
      repeat (2) begin @(posedge clk); #1; end
      src_addr = 20'h00F00; dst_addr = 20'h00F80; length = 16'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(t0, lat);
      check("restart_latency", lat, 10);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done_busy", busy, 0);
      check("start_in_done_req", bus_req, 0);
      repeat (4) @(negedge clk);
      check("restart_done_pulses", done_cnt - d0, 1);
      drain();
      check_mem();
      check("restart_untouched", mem[20'h00F80], 16'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
